// File: rtl/mod_counter_chain.sv
// Cascaded modulo-MODULUS up/down counter with parallel load and carry chain.
// Optional: define MOD_COUNTER_SATURATE_EN to hold at terminal instead of wrapping.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous active-high clear
//   i_enable     count-step request for this cycle
//   i_up_dn      1 = up, 0 = down (combinational effect on flags)
//   i_load       parallel load request (beats enable)
//   i_load_val   load value, digit k at [k*DIGIT_W +: DIGIT_W]
//   o_count      registered count, same packing as i_load_val
//   o_digit_tc   per-digit terminal flags for the current direction
//   o_carry_out  chain carry/borrow, combinational
module mod_counter_chain #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 10,
    parameter int DIGIT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_enable,
    input  logic                        i_up_dn,
    input  logic                        i_load,
    input  logic [DIGITS*DIGIT_W-1:0]   i_load_val,
    output logic [DIGITS*DIGIT_W-1:0]   o_count,
    output logic [DIGITS-1:0]           o_digit_tc,
    output logic                        o_carry_out
);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("mod_counter_chain: DIGITS must be 1..8");
        end
        if (MODULUS < 2 || MODULUS > (2 ** DIGIT_W)) begin : g_bad_mod
            $error("mod_counter_chain: MODULUS must be 2..2**DIGIT_W");
        end
    endgenerate

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULUS - 1);

    logic [DIGITS*DIGIT_W-1:0] r_count;
    logic [DIGITS*DIGIT_W-1:0] w_next;
    logic [DIGITS-1:0]         w_tc;
    logic [DIGITS-1:0]         w_step;
    logic                      w_step_req;
    logic                      w_all_tc;
    logic                      w_sat;

    assign w_step_req = i_enable & ~i_load;
    assign w_all_tc   = &w_tc;

`ifdef MOD_COUNTER_SATURATE_EN
    // Whole chain at terminal with a step pending: freeze instead of wrapping.
    assign w_sat = w_step_req & w_all_tc;
`else
    assign w_sat = 1'b0;
`endif

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            logic [DIGIT_W-1:0] w_d;
            logic [DIGIT_W-1:0] w_ld;
            logic [DIGIT_W-1:0] w_nd;

            assign w_d  = r_count[k*DIGIT_W +: DIGIT_W];
            assign w_ld = i_load_val[k*DIGIT_W +: DIGIT_W];

            assign w_tc[k] = i_up_dn ? (w_d == TOP)
                                     : (w_d == '0);

            // Ripple enable: a digit steps only when all lower digits are terminal.
            if (k == 0) begin : g_first
                assign w_step[k] = w_step_req;
            end else begin : g_rest
                assign w_step[k] = w_step[k-1] & w_tc[k-1];
            end

            always_comb begin
                w_nd = w_d;
                if (i_load) begin
                    w_nd = (w_ld > TOP) ? TOP : w_ld;
                end else if (w_step[k] && !w_sat) begin
                    if (i_up_dn) begin
                        w_nd = w_tc[k] ? '0 : w_d + DIGIT_W'(1);
                    end else begin
                        w_nd = w_tc[k] ? TOP : w_d - DIGIT_W'(1);
                    end
                end
            end

            assign w_next[k*DIGIT_W +: DIGIT_W] = w_nd;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count     = r_count;
    assign o_digit_tc  = w_tc;
    assign o_carry_out = w_step_req & ~reset & w_all_tc;

endmodule
